ring_renderer: RTL and testbench

- Pixel-rate stage directly downstream of the hsync/vsync timing generators in the ring display path.
- Consumes the 640x480 blank/sync signals and tracks the current pixel coordinate.
- Draws one filled annulus (ring) centred on a fixed point, using a pipelined squared-distance test.
- Radius animates once per frame. Outputs RGB plus sync signals delayed to stay aligned with the RGB.

---
 rtl/ring_renderer.sv | 128 ++++++++++++
 tb/tb_ring_renderer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_renderer.sv
// Ring renderer: tracks the pixel coordinate behind the 640x480 timing generators
// and draws one animated filled annulus through a 4-stage squared-distance pipeline.
module ring_renderer #(
   parameter int unsigned CX       = 320,
   parameter int unsigned CY       = 240,
   parameter int unsigned R_MIN    = 16,
   parameter int unsigned R_MAX    = 200,
   parameter int unsigned STEP     = 2,
   parameter int unsigned WIDTH    = 8,
   parameter logic [11:0] RING_RGB = 12'hF80,
   parameter logic [11:0] BG_RGB   = 12'h008
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       hblank,
   input  logic       vblank,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic [8:0] radius
);

   logic [9:0]  x;
   logic [9:0]  y;
   logic        hblank_q;
   logic        vblank_q;
   logic        frame_start;
   logic        sq_update;
   logic [9:0]  radius_step;
   logic [9:0]  radius_outer;
   logic [18:0] r_in2;
   logic [18:0] r_out2;
   logic [10:0] dx;
   logic [10:0] dy;
   logic [19:0] dx_ext;
   logic [19:0] dy_ext;
   logic [19:0] dx2;
   logic [19:0] dy2;
   logic [20:0] d2;
   logic        in_ring;
   logic [2:0]  blank_d;
   logic [3:0]  hs_d;
   logic [3:0]  vs_d;
   logic [11:0] rgb_q;

   assign frame_start  = vblank & ~vblank_q;
   assign radius_step  = {1'b0, radius} + 10'(STEP);
   assign radius_outer = {1'b0, radius} + 10'(WIDTH);
   // Sign-extended so an unsigned 20-bit multiply yields the exact square.
   assign dx_ext       = {{9{dx[10]}}, dx};
   assign dy_ext       = {{9{dy[10]}}, dy};
   assign d2           = {1'b0, dx2} + {1'b0, dy2};

   // The edge registers reset to "blanking" so leaving reset never fakes an edge.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         x        <= '0;
         y        <= '0;
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
      end else begin
         hblank_q <= hblank;
         vblank_q <= vblank;
         x        <= hblank ? 10'd0 : x + 10'd1;
         if (vblank)
            y <= '0;
         else if (hblank && !hblank_q)
            y <= y + 10'd1;
      end
   end

   // Radius steps on the vblank rise; the squared bounds follow one clock later.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         radius    <= 9'(R_MIN);
         sq_update <= 1'b0;
         r_in2     <= 19'(R_MIN * R_MIN);
         r_out2    <= 19'((R_MIN + WIDTH) * (R_MIN + WIDTH));
      end else begin
         sq_update <= frame_start;
         if (frame_start)
            radius <= (radius_step > 10'(R_MAX)) ? 9'(R_MIN) : radius_step[8:0];
         if (sq_update) begin
            r_in2  <= {10'b0, radius} * {10'b0, radius};
            r_out2 <= {9'b0, radius_outer} * {9'b0, radius_outer};
         end
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         dx      <= '0;
         dy      <= '0;
         dx2     <= '0;
         dy2     <= '0;
         in_ring <= 1'b0;
         blank_d <= '1;
         hs_d    <= '1;
         vs_d    <= '1;
         rgb_q   <= '0;
      end else begin
         dx      <= {1'b0, x} - 11'(CX);
         dy      <= {1'b0, y} - 11'(CY);
         dx2     <= dx_ext * dx_ext;
         dy2     <= dy_ext * dy_ext;
         in_ring <= (d2 >= {2'b0, r_in2}) && (d2 < {2'b0, r_out2});
         // Blank needs only three stages: the RGB register supplies the fourth.
         blank_d <= {blank_d[1:0], hblank | vblank};
         hs_d    <= {hs_d[2:0], hsync_in};
         vs_d    <= {vs_d[2:0], vsync_in};
         if (blank_d[2])
            rgb_q <= '0;
         else if (in_ring)
            rgb_q <= RING_RGB;
         else
            rgb_q <= BG_RGB;
      end
   end

   assign {red, green, blue} = rgb_q;
   assign hsync_out          = hs_d[3];
   assign vsync_out          = vs_d[3];

endmodule

// File: tb/tb_ring_renderer.sv
// Bench for ring_renderer: directed frames, an annulus model computed from pixel
// coordinates, a 4-deep expected queue and literal pixel expectations.
module tb_ring_renderer;

   localparam int W = 27;

   logic       Clk = 1'b0;
   logic       nReset = 1'b0;
   logic       hblank = 1'b0;
   logic       vblank = 1'b0;
   logic       hsync_in = 1'b0;
   logic       vsync_in = 1'b0;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;
   logic       hsync_out;
   logic       vsync_out;
   logic [8:0] radius;

   int          n_checks = 0;
   int          n_err = 0;
   int          drv_x = 0;
   int          drv_y = 0;
   int          model_r = 16;
   logic        lit_en = 1'b0;
   logic [11:0] lit_rgb = '0;
   logic        rand_sync = 1'b0;
   logic [11:0] model_rgb;
   logic [W-1:0] cmp_e;
   logic [W-1:0] exp_q[$];

   int          lit_x[7] = '{0, 320, 336, 340, 343, 344, 320};
   int          lit_y[7] = '{0, 240, 240, 240, 240, 240, 40};
   logic [11:0] lit_v[7] = '{12'h008, 12'h008, 12'hF80, 12'hF80, 12'hF80, 12'h008, 12'hF80};

   ring_renderer dut (
      .Clk       (Clk),
      .nReset    (nReset),
      .hblank    (hblank),
      .vblank    (vblank),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .radius    (radius)
   );

   always #5 Clk = ~Clk;

   function automatic logic [11:0] pixel_rgb(input int px, input int py, input int r);
      int d2;
      d2 = (px - 320) * (px - 320) + (py - 240) * (py - 240);
      if (d2 >= r * r && d2 < (r + 8) * (r + 8))
         return 12'hF80;
      return 12'h008;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic put(input logic hb, input logic vb, input int px, input int py);
      hblank   = hb;
      vblank   = vb;
      drv_x    = px;
      drv_y    = py;
      hsync_in = rand_sync ? 1'($urandom_range(0, 1)) : !hb;
      vsync_in = rand_sync ? 1'($urandom_range(0, 1)) : !vb;
      lit_en   = 1'b0;
      lit_rgb  = '0;
      if (!hb && !vb)
         for (int i = 0; i < 7; i++)
            if (px == lit_x[i] && py == lit_y[i]) begin
               lit_en  = 1'b1;
               lit_rgb = lit_v[i];
            end
   endtask

   task automatic drive(input logic hb, input logic vb, input int px, input int py);
      @(posedge Clk);
      #1;
      put(hb, vb, px, py);
   endtask

   task automatic drive_line(input int py, input int len, input int hb_len);
      for (int i = 0; i < len; i++)
         drive(1'b0, 1'b0, i, py);
      repeat (hb_len) drive(1'b1, 1'b0, 0, py);
   endtask

   task automatic lines_to(input int long_y, input int long_len);
      for (int i = 0; i < long_y; i++)
         drive_line(i, 1, 1);
      drive_line(long_y, long_len, 2);
   endtask

   // Radius must change on the clock that registers the vblank rise.
   task automatic vblank_period(input int n, input int exp_r);
      drive(1'b1, 1'b1, 0, 0);
      @(posedge Clk);
      model_r = (model_r + 2 > 200) ? 16 : model_r + 2;
      #2;
      check("radius_frame", 32'(radius), 32'(exp_r));
      repeat (n) drive(1'b1, 1'b1, 0, 0);
      drive(1'b1, 1'b0, 0, 0);
   endtask

   always @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         exp_q.delete();
      end else begin
         model_rgb = (hblank || vblank) ? 12'h000 : pixel_rgb(drv_x, drv_y, model_r);
         exp_q.push_back({lit_en, lit_rgb, model_rgb, hsync_in, vsync_in});
      end
   end

   always @(negedge Clk) begin
      if (nReset) begin
         check("radius", 32'(radius), 32'(model_r));
         if (exp_q.size() >= 4) begin
            cmp_e = exp_q.pop_front();
            check("rgb", 32'({red, green, blue}), 32'(cmp_e[13:2]));
            check("hsync_out", 32'(hsync_out), 32'(cmp_e[1]));
            check("vsync_out", 32'(vsync_out), 32'(cmp_e[0]));
            if (cmp_e[26])
               check("rgb_literal", 32'({red, green, blue}), 32'(cmp_e[25:14]));
         end
      end
   end

   initial begin
      repeat (3) @(posedge Clk);
      #1;
      check("reset_rgb", 32'({red, green, blue}), 32'h0);
      check("reset_hsync", 32'(hsync_out), 32'h1);
      check("reset_vsync", 32'(vsync_out), 32'h1);
      check("reset_radius", 32'(radius), 32'd16);

      // Leave reset on pixel (0,0) of line 0 at radius 16.
      @(posedge Clk);
      #1;
      nReset = 1'b1;
      put(1'b0, 1'b0, 0, 0);
      for (int i = 1; i < 8; i++)
         drive(1'b0, 1'b0, i, 0);
      repeat (2) drive(1'b1, 1'b0, 0, 0);
      for (int i = 1; i < 240; i++)
         drive_line(i, 1, 1);
      drive_line(240, 350, 2);
      vblank_period(4, 18);

      drive_line(0, 4, 2);
      vblank_period(4, 20);
      drive_line(0, 4, 2);
      vblank_period(4, 22);

      for (int k = 1; k <= 89; k++) begin
         drive_line(0, 2, 1);
         vblank_period(3, 22 + 2 * k);
      end

      // Frame drawn at radius 200, then the wrap back to 16.
      lines_to(40, 330);
      vblank_period(3, 16);
      lines_to(240, 350);
      vblank_period(3, 18);

      for (int i = 0; i <= 100; i++)
         drive(1'b0, 1'b0, i, 0);
      #1;
      nReset = 1'b0;
      model_r = 16;
      #1;
      check("midreset_rgb", 32'({red, green, blue}), 32'h0);
      check("midreset_hsync", 32'(hsync_out), 32'h1);
      check("midreset_vsync", 32'(vsync_out), 32'h1);
      check("midreset_radius", 32'(radius), 32'd16);
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("held_reset_hsync", 32'(hsync_out), 32'h1);
      check("held_reset_vsync", 32'(vsync_out), 32'h1);

      @(posedge Clk);
      #1;
      nReset = 1'b1;
      rand_sync = 1'b1;
      put(1'b1, 1'b0, 0, 0);
      repeat (24) drive(1'b1, 1'b0, 0, 0);
      rand_sync = 1'b0;
      repeat (6) drive(1'b1, 1'b0, 0, 0);
      @(posedge Clk);
      #2;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
